// File: rtl/sift_bram_pkg.sv
// Shared types for the SIFT frame-BRAM clients: read latency, pixel coordinate
// tag carried alongside each outstanding read, and the frame-reader FSM states.
package sift_bram_pkg;

  localparam int BRAM_READ_LATENCY = 2;
  localparam int PIX_COORD_W       = 16;

  typedef struct packed {
    logic [PIX_COORD_W-1:0] x;
    logic [PIX_COORD_W-1:0] y;
    logic                   last;
  } pix_tag_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } rd_state_t;

  // Number of reads currently travelling through the BRAM latency pipe.
  function automatic logic [1:0] count_inflight(input logic [BRAM_READ_LATENCY-1:0] v);
    logic [1:0] n;
    n = 2'd0;
    for (int i = 0; i < BRAM_READ_LATENCY; i++) begin
      n = n + {1'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/bram_frame_reader_chk.sv
// Invariant checks for the frame reader's credit scheme: the output FIFO
// never overflows and outstanding reads never exceed the FIFO capacity.
module bram_frame_reader_chk #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input logic             clka,
  input logic             rstb,
  input logic             i_push,
  input logic             i_pop,
  input logic [CNT_W-1:0] i_count,
  input logic [1:0]       i_inflight
);

  a_no_overflow: assert property (@(posedge clka) disable iff (rstb)
    !(i_push && !i_pop && (i_count == CNT_W'(DEPTH))));

  a_inflight_max: assert property (@(posedge clka) disable iff (rstb)
    (i_inflight <= 2'd2));

  a_credit: assert property (@(posedge clka) disable iff (rstb)
    ((int'(i_count) + int'(i_inflight)) <= DEPTH));

endmodule

// File: rtl/bram_frame_reader_fifo.sv
// Synchronous FIFO used as the frame reader's output buffer. Registered
// storage, no fall-through: a push into an empty FIFO shows up as o_valid on
// the following cycle. Push and pop together while full is accepted.
module bram_frame_reader_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clka,
  input  logic             rstb,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_pop;
  logic             w_do_push;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : p + PTR_W'(1);
  endfunction

  assign w_do_pop  = i_pop && (r_count != CNT_W'(0));
  assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

  // Storage, pointers and occupancy count.
  always_ff @(posedge clka) begin
    if (rstb) begin
      r_wr_ptr <= PTR_W'(0);
      r_rd_ptr <= PTR_W'(0);
      r_count  <= CNT_W'(0);
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= WIDTH'(0);
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != CNT_W'(0));
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : WIDTH'(0);
  assign o_count = r_count;

endmodule

// File: rtl/bram_frame_reader.sv
// Raster-scan reader for one WIDTH x HEIGHT frame held row-major in a
// 2-cycle-latency BRAM. Reads are issued only while the output FIFO has room
// for everything already in flight, so arbitrary downstream backpressure is
// absorbed without dropping data.
// Optional build macro: BRAM_FRAME_READER_DECIMATE_EN -- issue only even-x,
// even-y pixels and report halved coordinates (octave downsampling).
module bram_frame_reader
  import sift_bram_pkg::*;
#(
  parameter int PIXEL_W    = 8,
  parameter int WIDTH      = 64,
  parameter int HEIGHT     = 64,
  parameter int ADDR_W     = 12,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clka,
  input  logic               rstb,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  bram_addr,
  output logic               bram_en,
  output logic               bram_regce,
  input  logic [PIXEL_W-1:0] bram_dout,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [PIXEL_W-1:0] m_data,
  output logic [15:0]        m_x,
  output logic [15:0]        m_y,
  output logic               m_last
);

`ifdef BRAM_FRAME_READER_DECIMATE_EN
  localparam int X_STEP      = 2;
  localparam int Y_STEP      = 2;
  localparam int X_END       = WIDTH - 2;
  localparam int Y_END       = HEIGHT - 2;
  localparam int ROW_ADV     = WIDTH + 2;
  localparam int COORD_SHIFT = 1;
`else
  localparam int X_STEP      = 1;
  localparam int Y_STEP      = 1;
  localparam int X_END       = WIDTH - 1;
  localparam int Y_END       = HEIGHT - 1;
  localparam int ROW_ADV     = 1;
  localparam int COORD_SHIFT = 0;
`endif

  localparam int TAG_W  = $bits(pix_tag_t);
  localparam int FIFO_W = PIXEL_W + TAG_W;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int LAT    = BRAM_READ_LATENCY;

  rd_state_t                  r_state;
  rd_state_t                  w_state_nxt;
  logic [ADDR_W-1:0]          r_addr;
  logic [PIX_COORD_W-1:0]     r_x;
  logic [PIX_COORD_W-1:0]     r_y;
  logic                       r_busy;
  logic                       r_done;
  logic [LAT-1:0]             r_tag_v;
  pix_tag_t                   r_tag [LAT];

  logic                       w_issue;
  logic                       w_load;
  logic                       w_row_end;
  logic                       w_at_last;
  logic                       w_credit_ok;
  logic [1:0]                 w_inflight;
  pix_tag_t                   w_tag_in;
  pix_tag_t                   w_head;
  logic                       w_pop;
  logic                       w_fifo_valid;
  logic [CNT_W-1:0]           w_fifo_count;
  logic [FIFO_W-1:0]          w_fifo_din;
  logic [FIFO_W-1:0]          w_fifo_dout;

  assign w_inflight  = count_inflight(r_tag_v);
  assign w_credit_ok = (int'(w_fifo_count) + int'(w_inflight)) < FIFO_DEPTH;
  assign w_row_end   = (r_x == PIX_COORD_W'(X_END));
  assign w_at_last   = w_row_end && (r_y == PIX_COORD_W'(Y_END));
  assign w_pop       = w_fifo_valid && m_ready;

  // Coordinate tag that travels with the read being issued this cycle.
  always_comb begin
    w_tag_in      = '0;
    w_tag_in.x    = r_x >> COORD_SHIFT;
    w_tag_in.y    = r_y >> COORD_SHIFT;
    w_tag_in.last = w_at_last;
  end

  // Next-state and issue decision.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = ISSUE;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ISSUE: begin
        if (w_credit_ok) begin
          w_issue = 1'b1;
          if (w_at_last) begin
            w_state_nxt = DRAIN;
          end else begin
            w_state_nxt = ISSUE;
          end
        end else begin
          w_state_nxt = ISSUE;
        end
      end
      DRAIN: begin
        // The last pixel leaving the FIFO ends the frame; nothing else can be
        // outstanding behind it.
        if (w_pop && w_head.last && (w_inflight == 2'd0)) begin
          w_state_nxt = FINISH;
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      FINISH: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM state, status flags and the raster address/coordinate counters.
  always_ff @(posedge clka) begin
    if (rstb) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_addr  <= ADDR_W'(BASE_ADDR);
      r_x     <= PIX_COORD_W'(0);
      r_y     <= PIX_COORD_W'(0);
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ISSUE) || (w_state_nxt == DRAIN);
      r_done  <= (w_state_nxt == FINISH);
      if (w_load) begin
        r_addr <= ADDR_W'(BASE_ADDR);
        r_x    <= PIX_COORD_W'(0);
        r_y    <= PIX_COORD_W'(0);
      end else if (w_issue) begin
        if (w_row_end) begin
          r_x    <= PIX_COORD_W'(0);
          r_y    <= r_y + PIX_COORD_W'(Y_STEP);
          r_addr <= r_addr + ADDR_W'(ROW_ADV);
        end else begin
          r_x    <= r_x + PIX_COORD_W'(X_STEP);
          r_addr <= r_addr + ADDR_W'(X_STEP);
        end
      end
    end
  end

  // Tag pipe matching the BRAM read latency; its last stage lines up with bram_dout.
  always_ff @(posedge clka) begin
    if (rstb) begin
      r_tag_v <= LAT'(0);
      for (int i = 0; i < LAT; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_tag_v[0] <= w_issue;
      r_tag[0]   <= w_tag_in;
      for (int i = 1; i < LAT; i++) begin
        r_tag_v[i] <= r_tag_v[i-1];
        r_tag[i]   <= r_tag[i-1];
      end
    end
  end

  assign w_fifo_din = {bram_dout, r_tag[LAT-1]};

  bram_frame_reader_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clka    (clka),
    .rstb    (rstb),
    .i_push  (r_tag_v[LAT-1]),
    .i_data  (w_fifo_din),
    .i_pop   (w_pop),
    .o_data  (w_fifo_dout),
    .o_valid (w_fifo_valid),
    .o_count (w_fifo_count)
  );

  bram_frame_reader_chk #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_chk (
    .clka       (clka),
    .rstb       (rstb),
    .i_push     (r_tag_v[LAT-1]),
    .i_pop      (w_pop),
    .i_count    (w_fifo_count),
    .i_inflight (w_inflight)
  );

  assign w_head     = pix_tag_t'(w_fifo_dout[TAG_W-1:0]);
  assign m_valid    = w_fifo_valid;
  assign m_data     = w_fifo_dout[FIFO_W-1 -: PIXEL_W];
  assign m_x        = w_head.x;
  assign m_y        = w_head.y;
  assign m_last     = w_head.last;
  assign bram_en    = w_issue;
  assign bram_addr  = r_addr;
  assign bram_regce = 1'b1;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_bram_frame_reader.sv
// Self-checking bench for bram_frame_reader: a table of frame scenarios
// (ready duty, initial stall, mid-frame reset, repeated start) is replayed
// against a behavioural BRAM and a reference raster model.
module tb_bram_frame_reader;

  localparam int PW    = 8;
  localparam int W     = 4;
  localparam int AW    = 12;
  localparam int BASE  = 0;
  localparam int DEPTH = 4;
`ifdef BRAM_FRAME_READER_DECIMATE_EN
  localparam int H     = 4;
  localparam int NPIX  = (W / 2) * (H / 2);
`else
  localparam int H     = 3;
  localparam int NPIX  = W * H;
`endif
  localparam int RST_AT = (NPIX > 6) ? 5 : 2;

  logic          clka;
  logic          rstb;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] bram_addr;
  logic          bram_en;
  logic          bram_regce;
  logic [PW-1:0] bram_dout;
  logic          m_valid;
  logic          m_ready;
  logic [PW-1:0] m_data;
  logic [15:0]   m_x;
  logic [15:0]   m_y;
  logic          m_last;

  bram_frame_reader #(
    .PIXEL_W    (PW),
    .WIDTH      (W),
    .HEIGHT     (H),
    .ADDR_W     (AW),
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clka       (clka),
    .rstb       (rstb),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .bram_addr  (bram_addr),
    .bram_en    (bram_en),
    .bram_regce (bram_regce),
    .bram_dout  (bram_dout),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_x        (m_x),
    .m_y        (m_y),
    .m_last     (m_last)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  // Behavioural BRAM: address latched on an enabled edge, output register one edge later.
  logic [PW-1:0] bram_mem [0:(1<<AW)-1];
  logic [PW-1:0] b_lat;
  logic [PW-1:0] b_out;
  always @(posedge clka) begin
    if (bram_en) b_lat <= bram_mem[bram_addr];
    if (bram_regce) b_out <= b_lat;
  end
  assign bram_dout = b_out;

  typedef struct {
    int data;
    int x;
    int y;
    int last;
    int cyc;
  } hs_t;

  typedef struct {
    int ready_pct;
    int hold;
    int rst_at;
    bit dbl;
    bit chk_lat;
    int exp_pix;
    int exp_done;
  } vec_t;

  hs_t hs_q[$];
  int  addr_q[$];
  int  n_cmp, n_fail, cyc;
  int  issued, popped, done_cnt, done_cyc, last_hs_cyc, first_valid;
  bit  prev_stall;
  int  p_data, p_x, p_y, p_last;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference raster order: k-th emitted pixel -> coordinates and BRAM address.
  function automatic void model_pix(input int k, output int ex, output int ey, output int eaddr);
`ifdef BRAM_FRAME_READER_DECIMATE_EN
    ex    = k % (W / 2);
    ey    = k / (W / 2);
    eaddr = BASE + (2 * ey) * W + 2 * ex;
`else
    ex    = k % W;
    ey    = k / W;
    eaddr = BASE + k;
`endif
  endfunction

  // One clock: observe at the falling edge, return 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clka);
    if (rstb) begin
      issued     = 0;
      popped     = 0;
      prev_stall = 1'b0;
    end else begin
      if (bram_en) begin
        chk("credit", int'((issued - popped) < DEPTH), 1);
        addr_q.push_back(int'(bram_addr));
        issued++;
      end
      if (prev_stall) begin
        chk("stable_valid", int'(m_valid), 1);
        chk("stable_data", int'(m_data), p_data);
        chk("stable_xy", int'(m_x) * 65536 + int'(m_y), p_x * 65536 + p_y);
        chk("stable_last", int'(m_last), p_last);
      end
      if (m_valid && m_ready) begin
        hs_q.push_back('{int'(m_data), int'(m_x), int'(m_y), int'(m_last), cyc});
        popped++;
        last_hs_cyc = cyc;
      end
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = m_valid && !m_ready;
      p_data = int'(m_data);
      p_x    = int'(m_x);
      p_y    = int'(m_y);
      p_last = int'(m_last);
    end
    @(posedge clka);
    #1;
    cyc++;
  endtask

  task automatic chk_reset_vals();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_bram_en", int'(bram_en), 0);
    chk("rst_bram_addr", int'(bram_addr), BASE);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_data", int'(m_data), 0);
    chk("rst_m_xy", int'(m_x) + int'(m_y), 0);
    chk("rst_m_last", int'(m_last), 0);
  endtask

  task automatic run_frame(input vec_t v);
    int  s_cyc;
    int  post;
    bit  finished;
    int  ex, ey, ea, n;
    hs_q.delete();
    addr_q.delete();
    done_cnt    = 0;
    done_cyc    = -1;
    last_hs_cyc = -1;
    first_valid = -1;
    s_cyc       = cyc;
    post        = -1;
    finished    = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      start = (t == 0) || (v.dbl && t == 6);
      if (v.hold > 0 && t == v.hold) begin
        chk("hold_issue_count", addr_q.size(), DEPTH);
        chk("hold_fifo_valid", int'(m_valid), 1);
      end
      m_ready = (t < v.hold) ? 1'b0 : ($urandom_range(0, 99) < v.ready_pct);
      if (v.rst_at >= 0 && hs_q.size() >= v.rst_at) begin
        start = 1'b0;
        rstb  = 1'b1;
        tick();
        rstb  = 1'b0;
        chk_reset_vals();
        m_ready = 1'b1;
        repeat (10) tick();
        finished = 1'b1;
        break;
      end
      tick();
      if (done_cnt > 0 && post < 0) post = 0;
      if (post >= 0) begin
        post++;
        if (post > 10) begin
          finished = 1'b1;
          break;
        end
      end
    end
    start = 1'b0;
    if (!finished) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: frame did not finish, pixels seen %0d, expected %0d", hs_q.size(), v.exp_pix);
    end
    chk("pixel_count", hs_q.size(), v.exp_pix);
    chk("done_count", done_cnt, v.exp_done);
    n = (hs_q.size() < v.exp_pix) ? hs_q.size() : v.exp_pix;
    for (int k = 0; k < n; k++) begin
      model_pix(k, ex, ey, ea);
      chk("pix_data", hs_q[k].data, ea % 256);
      chk("pix_x", hs_q[k].x, ex);
      chk("pix_y", hs_q[k].y, ey);
      chk("pix_last", hs_q[k].last, int'(k == NPIX - 1));
    end
    n = (addr_q.size() < NPIX) ? addr_q.size() : NPIX;
    for (int k = 0; k < n; k++) begin
      model_pix(k, ex, ey, ea);
      chk("issue_addr", addr_q[k], ea);
    end
    if (v.rst_at < 0) chk("issue_count", addr_q.size(), NPIX);
    if (v.exp_done != 0) chk("done_after_last", done_cyc, last_hs_cyc + 1);
    if (v.chk_lat) begin
      chk("first_valid_latency", first_valid - s_cyc, 4);
      chk("frame_cycles", done_cyc - s_cyc + 1, NPIX + 5);
    end
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{100,  0,     -1, 1'b0, 1'b1, NPIX,   1};
    vecs[1] = '{ 30,  0,     -1, 1'b0, 1'b0, NPIX,   1};
    vecs[2] = '{100, 20,     -1, 1'b0, 1'b0, NPIX,   1};
    vecs[3] = '{100,  0, RST_AT, 1'b0, 1'b0, RST_AT, 0};
    vecs[4] = '{100,  0,     -1, 1'b0, 1'b1, NPIX,   1};
    vecs[5] = '{ 70,  0,     -1, 1'b1, 1'b0, NPIX,   1};
    vecs[6] = '{ 50,  0,     -1, 1'b0, 1'b0, NPIX,   1};

    n_cmp = 0;
    n_fail = 0;
    cyc = 0;
    issued = 0;
    popped = 0;
    prev_stall = 1'b0;
    for (int a = 0; a < (1 << AW); a++) bram_mem[a] = PW'(a);
    rstb = 1'b1;
    start = 1'b0;
    m_ready = 1'b0;
    @(posedge clka);
    #1;
    repeat (3) tick();
    rstb = 1'b0;
    chk_reset_vals();

    // start coincident with reset must not launch a frame
    addr_q.delete();
    rstb = 1'b1;
    start = 1'b1;
    tick();
    rstb = 1'b0;
    start = 1'b0;
    repeat (3) tick();
    chk("start_in_reset_busy", int'(busy), 0);
    chk("start_in_reset_issues", addr_q.size(), 0);

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
